// File: rtl/inst_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch front end and its
// pipeline neighbours.
package inst_prefetch_buffer_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  localparam int unsigned INST_BYTES = 4;

  // Bubble instruction (addi x0,x0,0) inserted by downstream stages on a stall.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_prefetch_buffer_fifo.sv
// inst_fifo: synchronous DEPTH-entry FIFO with push, pop, clear, count, full and empty.
// Pointers carry one extra MSB so full and empty are told apart without a separate flag.
module inst_fifo
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_data_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [WIDTH-1:0]       head_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a full FIFO may still accept a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: in-order word fetch into a small FIFO feeding IF/ID.
// Optional perf counters are built only when INST_PREFETCH_PERF_EN is defined.
module inst_prefetch_buffer
  import inst_prefetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              PC_W     = 64,
  parameter int              INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [PC_W-1:0]   if_pc,
  input  logic              if_ready,
  output logic [31:0]       perf_redirects,
  output logic [31:0]       perf_discards
);

  localparam int              AW           = $clog2(DEPTH);
  localparam int              EW           = PC_W + INST_W;
  localparam logic [AW+1:0]   CREDIT_LIMIT = (AW+2)'(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP      = PC_W'(INST_BYTES);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [AW:0]     outstanding_q, outstanding_d;
  logic [AW:0]     discard_q, discard_d;
  logic [PC_W-1:0] addr_mem_q [DEPTH];
  logic [AW-1:0]   addr_wr_q, addr_wr_d;
  logic [AW-1:0]   addr_rd_q, addr_rd_d;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [AW:0]     fifo_count;
  logic [EW-1:0]   fifo_head;
  logic [AW+1:0]   credits_used;
  logic            req_fire;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
  assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && (state_q == RUN) && !redirect_valid &&
                          (credits_used < CREDIT_LIMIT);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fifo_push = imem_rsp_valid && (state_q == RUN) && !redirect_valid;
  assign fifo_pop  = if_valid && if_ready && !redirect_valid;

  assign if_valid = !fifo_empty;
  assign if_inst  = fifo_empty ? '0 : fifo_head[INST_W-1:0];
  assign if_pc    = fifo_empty ? '0 : fifo_head[EW-1:INST_W];

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i ({addr_mem_q[addr_rd_q], imem_rsp_data}),
    .pop_i       (fifo_pop),
    .clear_i     (redirect_valid),
    .head_data_o (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    discard_d     = discard_q;
    addr_wr_d     = addr_wr_q;
    addr_rd_d     = addr_rd_q;
    outstanding_d = outstanding_q + (AW+1)'(req_fire) - (AW+1)'(imem_rsp_valid);
    if (redirect_valid) begin
      // The response arriving with the redirect is dropped here, not counted later.
      fetch_pc_d = redirect_pc;
      discard_d  = outstanding_q - (AW+1)'(imem_rsp_valid);
      state_d    = (discard_d != '0) ? DRAIN : RUN;
      addr_rd_d  = addr_wr_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
        addr_wr_d  = addr_wr_q + AW'(1);
      end
      if (fifo_push) addr_rd_d = addr_rd_q + AW'(1);
      if ((state_q == DRAIN) && imem_rsp_valid) begin
        discard_d = discard_q - (AW+1)'(1);
        if (discard_d == '0) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      addr_wr_q     <= '0;
      addr_rd_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      addr_wr_q     <= addr_wr_d;
      addr_rd_q     <= addr_rd_d;
    end
  end

  // Address queue: the PC of each issued request, consumed as its response lands.
  always_ff @(posedge clk) begin
    if (req_fire) addr_mem_q[addr_wr_q] <= fetch_pc_q;
  end

  assert property (@(posedge clk) disable iff (reset)
                   !(fifo_push && fifo_full && !fifo_pop));

`ifdef INST_PREFETCH_PERF_EN
  logic [31:0]   perf_redirects_q;
  logic [31:0]   perf_discards_q;
  logic          rsp_drop;
  logic [AW+1:0] discard_inc;
  logic [32:0]   redirects_sum;
  logic [32:0]   discards_sum;

  // Flushed valid entries count as discards alongside dropped responses.
  assign rsp_drop      = imem_rsp_valid && !fifo_push;
  assign discard_inc   = (redirect_valid ? {1'b0, fifo_count} : '0) + (AW+2)'(rsp_drop);
  assign redirects_sum = {1'b0, perf_redirects_q} + 33'(redirect_valid);
  assign discards_sum  = {1'b0, perf_discards_q} + 33'(discard_inc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_redirects_q <= '0;
      perf_discards_q  <= '0;
    end else begin
      perf_redirects_q <= redirects_sum[32] ? '1 : redirects_sum[31:0];
      perf_discards_q  <= discards_sum[32] ? '1 : discards_sum[31:0];
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_discards  = perf_discards_q;
`else
  assign perf_redirects = '0;
  assign perf_discards  = '0;
`endif

endmodule
